// File: rtl/sdram_arb_pkg.sv
// Shared types and sizing helpers for the SDRAM port arbiter.
// Imported by the interface, the round-robin picker and the top.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } arb_state_e;

  localparam int unsigned NumPortsDef = 4;
  localparam int unsigned IdxWidthDef = $clog2(NumPortsDef);
  localparam int unsigned StatWidth   = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter only ever holds 0..t-1 before the read is aborted
  function automatic int unsigned tmo_w(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester + sdram_ctrl user-port bundle for sdram_port_arbiter.
// Stats outputs exist only when SDRAM_ARB_STATS_EN is defined.
interface sdram_port_arbiter_if #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned DataWidth = 16
);
  logic [NumPorts-1:0]                i_req;
  logic [NumPorts-1:0]                i_we;
  logic [NumPorts-1:0][AddrWidth-1:0] i_addr;
  logic [NumPorts-1:0][DataWidth-1:0] i_wdata;
  logic [NumPorts-1:0]                o_gnt;
  logic [NumPorts-1:0]                o_rvalid;
  logic [NumPorts-1:0]                o_rerr;
  logic [DataWidth-1:0]               o_rdata;
  logic                               o_wr_req;
  logic [AddrWidth-1:0]               o_wr_addr;
  logic [DataWidth-1:0]               o_wr_data;
  logic                               o_rd_req;
  logic [AddrWidth-1:0]               o_rd_addr;
  logic [DataWidth-1:0]               i_rd_data;
  logic                               i_rd_valid;
  logic                               i_ctrl_ready;
`ifdef SDRAM_ARB_STATS_EN
  logic [NumPorts-1:0][15:0]          o_stat_grants;
  logic [15:0]                        o_stat_timeouts;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    input  i_rd_data, i_rd_valid, i_ctrl_ready,
    output o_gnt, o_rvalid, o_rerr, o_rdata,
    output o_wr_req, o_wr_addr, o_wr_data,
    output o_rd_req, o_rd_addr,
    output o_stat_grants, o_stat_timeouts
  );
  modport master (
    output i_req, i_we, i_addr, i_wdata,
    output i_rd_data, i_rd_valid, i_ctrl_ready,
    input  o_gnt, o_rvalid, o_rerr, o_rdata,
    input  o_wr_req, o_wr_addr, o_wr_data,
    input  o_rd_req, o_rd_addr,
    input  o_stat_grants, o_stat_timeouts
  );
`else
  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    input  i_rd_data, i_rd_valid, i_ctrl_ready,
    output o_gnt, o_rvalid, o_rerr, o_rdata,
    output o_wr_req, o_wr_addr, o_wr_data,
    output o_rd_req, o_rd_addr
  );
  modport master (
    output i_req, i_we, i_addr, i_wdata,
    output i_rd_data, i_rd_valid, i_ctrl_ready,
    input  o_gnt, o_rvalid, o_rerr, o_rdata,
    input  o_wr_req, o_wr_addr, o_wr_data,
    input  o_rd_req, o_rd_addr
  );
`endif
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after ptr, with wrap.
// Generic so it can back other bus arbiters.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one sdram_ctrl user port, one read outstanding.
// Define SDRAM_ARB_STATS_EN for saturating grant/timeout counters.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned RdTimeout = 64
) (
  input logic                i_clk,
  input logic                i_rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int unsigned IW = idx_w(NumPorts);
  localparam int unsigned TW = tmo_w(RdTimeout);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0] wr_data_q, wr_data_d;
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [NumPorts-1:0]  rvalid_q, rvalid_d;
  logic [NumPorts-1:0]  rerr_q, rerr_d;
  logic [NumPorts-1:0]  win_oh;
  logic [IW-1:0]        win_idx;
  logic                 win_any;
  logic [NumPorts-1:0]  own_oh;

  rr_picker #(.N(NumPorts), .IW(IW)) u_pick (
    .req (bus.i_req),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  assign own_oh = {{(NumPorts-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    we_d      = we_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    rvalid_d  = '0;
    rerr_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (win_any && bus.i_ctrl_ready) begin
          owner_d = win_idx;
          ptr_d   = win_idx;
          we_d    = bus.i_we[win_idx];
          if (bus.i_we[win_idx]) begin
            wr_addr_d = bus.i_addr[win_idx];
            wr_data_d = bus.i_wdata[win_idx];
          end else begin
            rd_addr_d = bus.i_addr[win_idx];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        cnt_d = cnt_q + TW'(1);
        // Data arriving on the last allowed cycle still beats the abort
        if (bus.i_rd_valid) begin
          rdata_d  = bus.i_rd_data;
          rvalid_d = own_oh;
          state_d  = IDLE;
        end else if (cnt_q == TW'(RdTimeout - 1)) begin
          rerr_d  = own_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NumPorts - 1);
      owner_q   <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      rvalid_q  <= '0;
      rerr_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
    end
  end

  assign bus.o_gnt     = (state_q == ISSUE) ? own_oh : '0;
  assign bus.o_wr_req  = (state_q == ISSUE) && we_q;
  assign bus.o_rd_req  = (state_q == ISSUE) && !we_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_rd_addr = rd_addr_q;
  assign bus.o_rdata   = rdata_q;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_rerr    = rerr_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [NumPorts-1:0][15:0] gcnt_q, gcnt_d;
  logic [15:0]               tcnt_q, tcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    tcnt_d = tcnt_q;
    if (state_q == ISSUE && gcnt_q[owner_q] != 16'hFFFF)
      gcnt_d[owner_q] = gcnt_q[owner_q] + 16'd1;
    if (|rerr_d && tcnt_q != 16'hFFFF)
      tcnt_d = tcnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign bus.o_stat_grants   = gcnt_q;
  assign bus.o_stat_timeouts = tcnt_q;
`endif
endmodule
